led_peripheral: RTL and testbench
=================================

# led_peripheral

Memory-mapped LED controller that sits on the peripheral port of the processor bus interconnect, answering the 0x8000_0000–0x8000_000F window. It holds a LED pattern register plus blink and PWM modulation logic, and drives the board LEDs through a registered output. Reads return register contents combinationally so the interconnect's combinational read mux sees data in the same cycle.

## Interface

Parameters:

- NUM_LEDS, 8, number of LED outputs (1–32).

Ports:

- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- periph_rd_en_i  in  1  read strobe from the interconnect, already qualified by the address decode.
- periph_wr_en_i  in  1  write strobe from the interconnect, already qualified by the address decode.
- periph_addr_i  in  32  byte address; only bits [3:2] are decoded, all other bits are ignored.
- periph_data_i  in  32  write data.
- periph_data_o  out  32  read data; combinational.
- leds_o  out  NUM_LEDS  LED drive, active-high, registered.

## Operation

Register map, selected by addr[3:2]; all registers are RW:

- 0x0 LED_REG: bits [NUM_LEDS-1:0] hold the pattern. Upper bits are not stored and read as 0.
- 0x4 CTRL: bit0 BLINK_EN, bit1 PWM_EN. Bits [31:2] read as 0.
- 0x8 BLINK_PERIOD: 32-bit half-period, in clk cycles.
- 0xC PWM_DUTY: bits [7:0] hold the duty. Bits [31:8] read as 0.

Write behaviour:

- When periph_wr_en_i=1, the addressed register loads at the rising edge.
- A write to CTRL or BLINK_PERIOD also clears blink_cnt to 0 and sets blink_phase to 1.

Read behaviour:

- periph_data_o is the addressed register, zero-extended, while periph_rd_en_i=1. Otherwise it is 0.
- If rd and wr are asserted in the same cycle, the write still happens and the read returns the pre-write value.

Blink engine:

- Uses a 32-bit blink_cnt and a 1-bit blink_phase.
- When BLINK_EN=0: blink_cnt is held at 0 and blink_phase at 1.
- When BLINK_EN=1 and BLINK_PERIOD=0: same as disabled; the LEDs stay steadily on.
- When BLINK_EN=1 and BLINK_PERIOD=P>0: blink_cnt increments each cycle. When blink_cnt==P-1, it wraps to 0 and blink_phase inverts.

PWM engine:

- pwm_cnt is an 8-bit counter that runs freely and wraps 255→0. It is never cleared except by reset.
- pwm_on = (pwm_cnt < PWM_DUTY).
- DUTY=0 gives never on; DUTY=255 gives on for 255 of every 256 cycles.
- Writing PWM_DUTY does not disturb pwm_cnt.

Output:

- leds_o is registered as LED_REG & {NUM_LEDS{(blink_phase | ~BLINK_EN) & (pwm_on | ~PWM_EN)}}, evaluated from the current-cycle state.

## Timing

- Reset (async assert): LED_REG=0, CTRL=0, BLINK_PERIOD=0, PWM_DUTY=0, blink_cnt=0, blink_phase=1, pwm_cnt=0, leds_o=0. periph_data_o=0 while rd_en=0.
- Reset release is synchronous to clk; the first update happens on the first rising edge with rst_n=1.
- Write latency: a register written at edge N holds its new value after edge N; leds_o reflects it after edge N+1 (1-cycle output latency).
- Read latency: 0 cycles (combinational). There is no wait state and no handshake; every access completes in the cycle its strobe is high.
- Blink: with CTRL written at edge N (BLINK_EN=1, P already loaded):
  - blink_phase=1 for cycles N..N+P-1.
  - It toggles at edge N+P, then every P edges after that.
  - leds_o lags blink_phase by 1 cycle.
- A reset mid-blink or mid-PWM returns everything to reset values immediately. No state survives reset.
- A write to BLINK_PERIOD while blinking restarts the phase at 1 and the count at 0. The new P applies at once.

## Test plan

- Reset: hold rst_n=0 with random bus activity → leds_o=0, and all four registers read 0 after release.
- Static write: write LED_REG=0xA5 at edge N → leds_o=0xA5 after edge N+1; a read at 0x0 returns 0x000000A5; a write of 0xFFFFFF00 reads back 0x00000000.
- Blink: write BLINK_PERIOD=4, then CTRL=1, with LED_REG=0xFF → leds_o alternates 0xFF for 4 cycles and 0x00 for 4 cycles, starting one cycle after the CTRL write. With BLINK_PERIOD=0 it stays 0xFF.
- PWM: CTRL=2, DUTY=64, LED_REG=0x0F → over any 256-cycle window, leds_o=0x0F for exactly 64 cycles. DUTY=0 gives constant 0; DUTY=255 gives 255 of 256 cycles.
- Simultaneous rd/wr at 0x4, old value 0, writing 3 → same-cycle read returns 0; the next read returns 3.
- Async reset asserted mid-blink, between clock edges → leds_o drops to 0 without waiting for a clock edge; after release, CTRL reads 0.

Source files
------------

// File: rtl/led_peripheral.sv
// rtl/led_peripheral.sv - memory-mapped LED pattern register with blink and PWM modulation
module led_peripheral #(
    parameter int NUM_LEDS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                periph_rd_en_i,
    input  logic                periph_wr_en_i,
    input  logic [31:0]         periph_addr_i,
    input  logic [31:0]         periph_data_i,
    output logic [31:0]         periph_data_o,
    output logic [NUM_LEDS-1:0] leds_o
);

    localparam logic [1:0] ADDR_LED    = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_DUTY   = 2'd3;

    logic [NUM_LEDS-1:0] led_reg;
    logic [1:0]          ctrl;
    logic [31:0]         blink_period;
    logic [7:0]          pwm_duty;
    logic [31:0]         blink_cnt;
    logic                blink_phase;
    logic [7:0]          pwm_cnt;

    logic [1:0] reg_sel;
    logic       wr_led;
    logic       wr_ctrl;
    logic       wr_period;
    logic       wr_duty;
    logic       blink_en;
    logic       pwm_en;
    logic       pwm_on;
    logic       led_gate;
    logic       unused_addr_bits;

    assign reg_sel   = periph_addr_i[3:2];
    assign wr_led    = periph_wr_en_i && (reg_sel == ADDR_LED);
    assign wr_ctrl   = periph_wr_en_i && (reg_sel == ADDR_CTRL);
    assign wr_period = periph_wr_en_i && (reg_sel == ADDR_PERIOD);
    assign wr_duty   = periph_wr_en_i && (reg_sel == ADDR_DUTY);

    assign blink_en  = ctrl[0];
    assign pwm_en    = ctrl[1];
    assign pwm_on    = (pwm_cnt < pwm_duty);
    assign led_gate  = (blink_phase | ~blink_en) & (pwm_on | ~pwm_en);

    assign unused_addr_bits = ^{periph_addr_i[31:4], periph_addr_i[1:0]};

    // Reads see the pre-write register value when rd and wr coincide.
    always_comb begin
        periph_data_o = 32'd0;
        if (periph_rd_en_i) begin
            case (reg_sel)
                ADDR_LED:    periph_data_o = 32'(led_reg);
                ADDR_CTRL:   periph_data_o = {30'd0, ctrl};
                ADDR_PERIOD: periph_data_o = blink_period;
                default:     periph_data_o = {24'd0, pwm_duty};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_reg      <= '0;
            ctrl         <= 2'd0;
            blink_period <= 32'd0;
            pwm_duty     <= 8'd0;
        end else begin
            if (wr_led)    led_reg      <= periph_data_i[NUM_LEDS-1:0];
            if (wr_ctrl)   ctrl         <= periph_data_i[1:0];
            if (wr_period) blink_period <= periph_data_i;
            if (wr_duty)   pwm_duty     <= periph_data_i[7:0];
        end
    end

    // A CTRL or period write restarts the blink at the on-phase with the new settings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= 32'd0;
            blink_phase <= 1'b1;
        end else if (wr_ctrl || wr_period || !blink_en || (blink_period == 32'd0)) begin
            blink_cnt   <= 32'd0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == blink_period - 32'd1) begin
            blink_cnt   <= 32'd0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 8'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_o <= '0;
        end else begin
            leds_o <= led_reg & {NUM_LEDS{led_gate}};
        end
    end

endmodule

// File: tb/tb_led_peripheral.sv
// tb/tb_led_peripheral.sv - scoreboard bench for led_peripheral
`timescale 1ns/100ps
module tb_led_peripheral;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic [7:0]  leds;
    logic        led_chk = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t rd_q[$];
    exp_t led_q[$];

    led_peripheral #(.NUM_LEDS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .periph_rd_en_i (rd_en),
        .periph_wr_en_i (wr_en),
        .periph_addr_i  (addr),
        .periph_data_i  (wdata),
        .periph_data_o  (rdata),
        .leds_o         (leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rd_en) begin
            if (rd_q.size() == 0) check("rd_q_underflow", rdata, 32'hxxxx_xxxx);
            else begin
                e = rd_q.pop_front();
                check(e.name, rdata, e.exp);
            end
        end
        if (led_chk) begin
            if (led_q.size() == 0) check("led_q_underflow", {24'd0, leds}, 32'hxxxx_xxxx);
            else begin
                e = led_q.pop_front();
                check(e.name, {24'd0, leds}, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        rd_q.push_back('{name, exp});
        addr = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic rdwr(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
        rd_q.push_back('{name, exp});
        addr = a; wdata = d; rd_en = 1'b1; wr_en = 1'b1;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic led_exp(input string name, input logic [31:0] exp);
        led_q.push_back('{name, exp});
        led_chk = 1'b1;
        tick();
        led_chk = 1'b0;
    endtask

    task automatic pwm_window(input string name, input logic [7:0] duty, input int exp_on);
        int on_cnt;
        int bad;
        wr(32'hC, {24'd0, duty});
        tick();
        tick();
        on_cnt = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (leds == 8'h0F) on_cnt++;
            else if (leds != 8'h00) bad++;
            tick();
        end
        check(name, on_cnt, exp_on);
        check({name, "_levels"}, bad, 0);
    endtask

    initial begin
        tick();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'($urandom);
            rd_en = 1'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            if (rd_en) rd_q.push_back('{"reset_rd", 32'd0});
            led_q.push_back('{"reset_leds", 32'd0});
            led_chk = 1'b1;
            tick();
        end
        led_chk = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        rst_n = 1'b1;
        rd("post_reset_led",    32'h8000_0000, 32'd0);
        rd("post_reset_ctrl",   32'h8000_0004, 32'd0);
        rd("post_reset_period", 32'h8000_0008, 32'd0);
        rd("post_reset_duty",   32'h8000_000C, 32'd0);

        rdwr("rdwr_same_cycle", 32'h4, 32'd3, 32'd0);
        rd("rdwr_next_read", 32'h4, 32'd3);
        wr(32'h4, 32'd0);

        wr(32'h0, 32'hA5);
        led_exp("static_latency", 32'h00);
        led_exp("static_leds", 32'hA5);
        rd("static_rd", 32'h8000_0000, 32'h0000_00A5);
        wr(32'h0, 32'hFFFF_FF00);
        rd("led_upper_bits", 32'h0, 32'd0);
        wr(32'h4, 32'hFFFF_FFFC);
        rd("ctrl_upper_bits", 32'hFFFF_FFF4, 32'd0);
        wr(32'hC, 32'h0000_1234);
        rd("duty_upper_bits", 32'hC, 32'h34);
        wr(32'hC, 32'd0);
        wr(32'h8, 32'hDEAD_BEEF);
        rd("period_rw", 32'h8, 32'hDEAD_BEEF);

        wr(32'h0, 32'hFF);
        wr(32'h8, 32'd4);
        wr(32'h4, 32'd1);
        tick();
        for (int i = 0; i < 16; i++)
            led_exp($sformatf("blink_%0d", i), ((i / 4) % 2 == 0) ? 32'hFF : 32'h00);
        wr(32'h8, 32'd0);
        tick();
        for (int i = 0; i < 6; i++) led_exp("blink_p0_steady", 32'hFF);

        wr(32'h4, 32'd0);
        wr(32'h0, 32'h0F);
        wr(32'h4, 32'd2);
        pwm_window("pwm_duty64", 8'd64, 64);
        pwm_window("pwm_duty0", 8'd0, 0);
        pwm_window("pwm_duty255", 8'd255, 255);

        wr(32'h4, 32'd0);
        wr(32'h0, 32'hFF);
        wr(32'h8, 32'd4);
        wr(32'h4, 32'd1);
        tick();
        check("pre_async_leds", {24'd0, leds}, 32'hFF);
        #2 rst_n = 1'b0;
        #1 check("async_reset_leds", {24'd0, leds}, 32'h00);
        tick();
        tick();
        rst_n = 1'b1;
        rd("after_async_ctrl", 32'h4, 32'd0);
        rd("after_async_led", 32'h0, 32'd0);
        led_exp("after_async_leds", 32'h00);

        tick();
        check("rd_q_drained", rd_q.size(), 0);
        check("led_q_drained", led_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
